sram_address: RTL and testbench

- One 32-bit word of the data SRAM, organised as four independently writable byte lanes.
- The SRAM top level instantiates 128 of these, one per word line.
- It drives the word line (WL) of the addressed word only.
- It broadcasts datain, byte_sel and the read/write pulses to all words, and muxes each word's dataout by address.

---
 rtl/sram_address_if.sv | 30 +++
 rtl/sram_address.sv | 58 +++++
 tb/tb_sram_address.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/sram_address_if.sv
// ----------------------------------------------------------------------------
// sram_address_if : broadcast bus between the SRAM top level and one word
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface sram_address_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int NUM_BYTES = DATA_WIDTH / 8;

  logic                  WL;
  logic [NUM_BYTES-1:0]  byte_sel;
  logic [DATA_WIDTH-1:0] datain;
  logic [DATA_WIDTH-1:0] dataout;
  logic                  read_pulse;
  logic                  write_pulse;

  modport master (
    output WL, byte_sel, datain, read_pulse, write_pulse,
    input  dataout
  );

  modport slave (
    input  WL, byte_sel, datain, read_pulse, write_pulse,
    output dataout
  );
endinterface

`default_nettype wire

// File: rtl/sram_address.sv
// ----------------------------------------------------------------------------
// sram_address : one SRAM word of byte-writable lanes with registered readout
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sram_address #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTES  = DATA_WIDTH / 8
) (
  input  wire logic      clk,
  input  wire logic      rst,
  sram_address_if.slave  bus
);

  logic [7:0]            mem_q [NUM_BYTES];
  logic [7:0]            mem_d [NUM_BYTES];
  logic [DATA_WIDTH-1:0] dataout_q;
  logic [DATA_WIDTH-1:0] dataout_d;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_en;
  logic                  rd_en;

  // A write wins over a simultaneous read; the read is dropped entirely.
  assign wr_en = bus.WL & bus.write_pulse;
  assign rd_en = bus.WL & bus.read_pulse & ~bus.write_pulse;

  for (genvar k = 0; k < NUM_BYTES; k++) begin : g_lane
    assign mem_d[k] = (wr_en && bus.byte_sel[k]) ? bus.datain[8*k +: 8] : mem_q[k];
    assign rd_data[8*k +: 8] = bus.byte_sel[k] ? mem_q[k] : 8'h00;
  end

  always_comb begin
    dataout_d = dataout_q;
    if (rd_en) begin
      dataout_d = rd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        mem_q[k] <= 8'h00;
      end
      dataout_q <= '0;
    end else begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        mem_q[k] <= mem_d[k];
      end
      dataout_q <= dataout_d;
    end
  end

  assign bus.dataout = dataout_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_address.sv
// ----------------------------------------------------------------------------
// tb_sram_address : directed bench with a word-level reference model
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sram_address;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  bit   started;

  sram_address_if #(.DATA_WIDTH(32)) bus_if ();

  sram_address #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: whole-word view of storage and of the read register.
  logic [31:0] m_mem;
  logic [31:0] m_out;

  function automatic logic [31:0] lane_mask(input logic [3:0] bs);
    logic [31:0] m;
    m = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (bs[k]) m = m | (32'hFF << (8 * k));
    end
    return m;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mem = 32'h0;
      m_out = 32'h0;
    end else if (bus_if.WL) begin
      if (bus_if.write_pulse)
        m_mem = (m_mem & ~lane_mask(bus_if.byte_sel)) | (bus_if.datain & lane_mask(bus_if.byte_sel));
      else if (bus_if.read_pulse)
        m_out = m_mem & lane_mask(bus_if.byte_sel);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: dataout=%08h expected=%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) check("model", bus_if.dataout, m_out);
  end

  task automatic op(input logic wl, input logic rd, input logic wr,
                    input logic [3:0] bs, input logic [31:0] din);
    @(posedge clk);
    #2;
    bus_if.WL          = wl;
    bus_if.read_pulse  = rd;
    bus_if.write_pulse = wr;
    bus_if.byte_sel    = bs;
    bus_if.datain      = din;
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    started = 1'b0;
    rst     = 1'b0;
    bus_if.WL = 1'b0; bus_if.read_pulse = 1'b0; bus_if.write_pulse = 1'b0;
    bus_if.byte_sel = 4'h0; bus_if.datain = 32'h0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    started = 1'b1;
    check("reset_state", bus_if.dataout, 32'h0);

    // Full write then full read
    op(1'b1, 1'b0, 1'b1, 4'hF, 32'h1234_5678);
    op(1'b1, 1'b1, 1'b0, 4'hF, 32'h0);
    check("before_read_edge", bus_if.dataout, 32'h0);
    idle();
    check("full_rw", bus_if.dataout, 32'h1234_5678);

    // Byte-lane write
    op(1'b1, 1'b0, 1'b1, 4'b0101, 32'hAABB_CCDD);
    op(1'b1, 1'b1, 1'b0, 4'hF, 32'h0);
    idle();
    check("lane_write", bus_if.dataout, 32'h12BB_56DD);

    // Masked and empty reads
    op(1'b1, 1'b1, 1'b0, 4'b1000, 32'h0);
    idle();
    check("masked_read", bus_if.dataout, 32'h1200_0000);
    op(1'b1, 1'b1, 1'b0, 4'b0000, 32'h0);
    idle();
    check("empty_mask_read", bus_if.dataout, 32'h0);
    op(1'b1, 1'b0, 1'b1, 4'b0000, 32'hFFFF_FFFF);
    op(1'b1, 1'b1, 1'b0, 4'b0110, 32'h0);
    idle();
    check("empty_mask_write", bus_if.dataout, 32'h00BB_5600);

    // Deselect isolation
    op(1'b1, 1'b1, 1'b0, 4'hF, 32'h0);
    idle();
    op(1'b0, 1'b0, 1'b1, 4'hF, 32'hFFFF_FFFF);
    op(1'b0, 1'b1, 1'b0, 4'h3, 32'h0);
    op(1'b0, 1'b1, 1'b1, 4'hF, 32'h0F0F_0F0F);
    idle();
    check("deselect_hold", bus_if.dataout, 32'h12BB_56DD);
    op(1'b1, 1'b1, 1'b0, 4'h3, 32'h0);
    idle();
    check("deselect_contents", bus_if.dataout, 32'h0000_56DD);

    // Simultaneous pulses: write done, read suppressed
    op(1'b1, 1'b1, 1'b1, 4'hF, 32'hCAFE_F00D);
    idle();
    check("simul_hold", bus_if.dataout, 32'h0000_56DD);
    op(1'b1, 1'b1, 1'b0, 4'hF, 32'h0);
    idle();
    check("simul_then_read", bus_if.dataout, 32'hCAFE_F00D);

    // Level-held read refreshes each cycle as the mask changes
    op(1'b1, 1'b1, 1'b0, 4'h1, 32'h0);
    op(1'b1, 1'b1, 1'b0, 4'h4, 32'h0);
    check("held_read_1", bus_if.dataout, 32'h0000_000D);
    idle();
    check("held_read_2", bus_if.dataout, 32'h00FE_0000);

    // Asynchronous reset mid-cycle with DEAD_BEEF stored
    op(1'b1, 1'b0, 1'b1, 4'hF, 32'hDEAD_BEEF);
    op(1'b1, 1'b1, 1'b0, 4'hF, 32'h0);
    idle();
    check("pre_reset", bus_if.dataout, 32'hDEAD_BEEF);
    #1 rst = 1'b1;
    #1 check("async_reset", bus_if.dataout, 32'h0);
    op(1'b1, 1'b0, 1'b1, 4'hF, 32'h5555_AAAA);
    op(1'b1, 1'b1, 1'b0, 4'hF, 32'h0);
    check("reset_held", bus_if.dataout, 32'h0);
    rst = 1'b0;
    idle();
    check("reset_ignores_read", bus_if.dataout, 32'h0);
    op(1'b1, 1'b1, 1'b0, 4'hF, 32'h0);
    idle();
    check("post_reset_read", bus_if.dataout, 32'h0);

    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
